// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence link (pattern transmitter and
// detector): state encodings, the reference pattern and the idle line level.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } seq_state_t;

    // Reference pattern; the detector matches against the same constant.
    localparam logic [3:0] PAT_0101 = 4'b0101;

    // Line level while nothing is being transmitted.
    localparam logic IDLE_LEVEL_DEF = 1'b1;

    // A repeat count of zero still sends the pattern once.
    function automatic logic [3:0] rep_eff(input logic [3:0] rep);
        return (rep == 4'd0) ? 4'd1 : rep;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register, MSB first, zero fill from the LSB.
module piso_shift #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             nCR,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             ser_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    // Shift register with asynchronous clear.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB first,
// Rep times, with an optional idle gap between repetitions.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | line at idle level, Ready=1, waiting for Start
//   ST_SHIFT | driving pattern bits, bit_q counts position in the repetition
//   ST_GAP   | line at idle level between repetitions, gap_q counts down
//   2'b11    | unused, falls back to ST_IDLE
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic             CP,
    input  logic             nCR,
    input  logic             Start,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [3:0]       Rep,
    output logic             Sout,
    output logic             Ready,
    output logic             Busy,
    output logic             Done
);

    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    BIT_LST = CW'(WIDTH - 1);
    localparam int               GAP_M1  = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [3:0]       GAP_LD  = 4'(GAP_M1);

    seq_state_t       state_q, state_d;
    logic             sout_q, sout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [3:0]       rep_q, rep_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [3:0]       gap_q, gap_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_din;
    logic             sr_ser;

    // The MSB goes straight to Sout on load, so the shifter is preloaded with
    // the remaining bits already moved up; its MSB is always the next bit due.
    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .CP    (CP),
        .nCR   (nCR),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .ser_o (sr_ser)
    );

    // Next-state and next-output computation for the transmit sequencer.
    always_comb begin
        state_d  = state_q;
        sout_d   = sout_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pat_d    = pat_q;
        rep_d    = rep_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = {pat_q[WIDTH-2:0], 1'b0};

        case (state_q)
            ST_IDLE: begin
                sout_d  = IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (Start && ready_q) begin
                    pat_d   = Pattern;
                    rep_d   = rep_eff(Rep);
                    bit_d   = '0;
                    sout_d  = Pattern[WIDTH-1];
                    sr_din  = {Pattern[WIDTH-2:0], 1'b0};
                    sr_load = 1'b1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_q == BIT_LST) begin
                    bit_d = '0;
                    if (rep_q > 4'd1) begin
                        rep_d = rep_q - 4'd1;
                        if (GAP == 0) begin
                            sout_d  = pat_q[WIDTH-1];
                            sr_load = 1'b1;
                        end else begin
                            gap_d   = GAP_LD;
                            sout_d  = IDLE_LEVEL;
                            state_d = ST_GAP;
                        end
                    end else begin
                        sout_d  = IDLE_LEVEL;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_d    = bit_q + 1'b1;
                    sout_d   = sr_ser;
                    sr_shift = 1'b1;
                end
            end

            ST_GAP: begin
                sout_d = IDLE_LEVEL;
                if (gap_q == 4'd0) begin
                    sout_d  = pat_q[WIDTH-1];
                    sr_load = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            default: begin
                sout_d  = IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, held pattern and all outputs registered together.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q <= ST_IDLE;
            sout_q  <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    assign Sout  = sout_q;
    assign Ready = ready_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with no gap, one with GAP=2,
// both fed the same stimulus.
module tb_seq_pattern_tx;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       Start = 1'b0;
    logic [3:0] Pattern = 4'b0000;
    logic [3:0] Rep = 4'd0;

    logic sout0, ready0, busy0, done0;
    logic sout2, ready2, busy2, done2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CP = ~CP;

    seq_pattern_tx #(.WIDTH(4), .GAP(0), .IDLE_LEVEL(1'b1)) dut0 (
        .CP(CP), .nCR(nCR), .Start(Start), .Pattern(Pattern), .Rep(Rep),
        .Sout(sout0), .Ready(ready0), .Busy(busy0), .Done(done0)
    );

    seq_pattern_tx #(.WIDTH(4), .GAP(2), .IDLE_LEVEL(1'b1)) dut2 (
        .CP(CP), .nCR(nCR), .Start(Start), .Pattern(Pattern), .Rep(Rep),
        .Sout(sout2), .Ready(ready2), .Busy(busy2), .Done(done2)
    );

    typedef struct {
        logic [3:0]  pat;
        logic [3:0]  rep;
        bit          use_gap;
        bit          mid_start;
        int          len;
        logic [31:0] exp;   // expected stream, first bit at position len-1
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs(input bit g);
        return g ? {sout2, ready2, busy2, done2} : {sout0, ready0, busy0, done0};
    endfunction

    // Sends one transfer and checks every cycle of it plus the Done cycle.
    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] o;
        logic       eb;
        @(negedge CP);
        Pattern = v.pat;
        Rep     = v.rep;
        Start   = 1'b1;
        @(posedge CP);
        #1 Start = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            @(negedge CP);
            o  = outs(v.use_gap);
            eb = v.exp[v.len-1-i];
            chk({tag, " sout"}, 32'(o[3]), 32'(eb));
            chk({tag, " ready/busy/done"}, 32'(o[2:0]), 32'b010);
            if (v.mid_start && i == 1) begin
                Pattern = 4'b0000;
                Rep     = 4'd5;
                Start   = 1'b1;
            end
            if (v.mid_start && i == 2) begin
                Start = 1'b0;
            end
        end
        @(negedge CP);
        chk({tag, " done cycle"}, 32'(outs(v.use_gap)), 32'b1101);
        @(negedge CP);
        chk({tag, " after done"}, 32'(outs(v.use_gap)), 32'b1100);
        // let the other instance finish whatever it was doing
        for (int c = 0; c < 40 && (busy0 || busy2); c++) @(negedge CP);
        chk({tag, " both idle"}, 32'({busy0, busy2}), 32'b00);
        repeat (2) @(negedge CP);
    endtask

    initial begin
        logic [4:0] held_bits;
        logic [4:0] held_done;
        vec_t       v;

        vecs[0] = '{pat: 4'b0101, rep: 4'd1, use_gap: 1'b0, mid_start: 1'b0, len: 4,  exp: 32'b0101};
        vecs[1] = '{pat: 4'b0101, rep: 4'd3, use_gap: 1'b0, mid_start: 1'b0, len: 12, exp: 32'b010101010101};
        vecs[2] = '{pat: 4'b1100, rep: 4'd2, use_gap: 1'b1, mid_start: 1'b0, len: 10, exp: 32'b1100111100};
        vecs[3] = '{pat: 4'b1001, rep: 4'd0, use_gap: 1'b0, mid_start: 1'b1, len: 4,  exp: 32'b1001};
        vecs[4] = '{pat: 4'b0110, rep: 4'd2, use_gap: 1'b1, mid_start: 1'b0, len: 10, exp: 32'b0110110110};
        vecs[5] = '{pat: 4'b1010, rep: 4'd2, use_gap: 1'b0, mid_start: 1'b0, len: 8,  exp: 32'b10101010};

        // reset state
        #12;
        chk("reset dut0", 32'(outs(1'b0)), 32'b1100);
        chk("reset dut2", 32'(outs(1'b1)), 32'b1100);
        @(negedge CP);
        nCR = 1'b1;
        repeat (2) @(negedge CP);
        chk("post reset idle", 32'(outs(1'b0)), 32'b1100);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // asynchronous reset while bit 2 is on the line
        @(negedge CP);
        Pattern = 4'b1100;
        Rep     = 4'd2;
        Start   = 1'b1;
        @(posedge CP);
        #1 Start = 1'b0;
        @(posedge CP);
        @(posedge CP);
        #2;
        chk("bit2 before reset", 32'({sout0, busy0}), 32'b01);
        nCR = 1'b0;
        #1;
        chk("async rst dut0", 32'(outs(1'b0)), 32'b1100);
        chk("async rst dut2", 32'(outs(1'b1)), 32'b1100);
        @(negedge CP);
        nCR = 1'b1;
        repeat (2) @(negedge CP);
        v = '{pat: 4'b0101, rep: 4'd1, use_gap: 1'b0, mid_start: 1'b0, len: 4, exp: 32'b0101};
        run_vec(v, "after rst");

        // Start held high: one idle/Done cycle between back-to-back transfers
        held_bits = 5'b01101;
        held_done = 5'b00001;
        @(negedge CP);
        Pattern = 4'b0110;
        Rep     = 4'd1;
        Start   = 1'b1;
        @(posedge CP);
        for (int i = 0; i < 10; i++) begin
            @(negedge CP);
            chk("held sout", 32'(sout0), 32'(held_bits[4 - (i % 5)]));
            chk("held done", 32'(done0), 32'(held_done[4 - (i % 5)]));
            chk("held gap inst", 32'({sout2, done2}), 32'({held_bits[4 - (i % 5)], held_done[4 - (i % 5)]}));
        end
        Start = 1'b0;
        repeat (2) @(negedge CP);
        chk("held stop", 32'(outs(1'b0)), 32'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter; the driving end of the serial sequence-detector link.
- On a start request it captures a WIDTH-bit pattern (default 0101) and repeat count, then shifts the pattern out MSB-first on Sout, one bit per CP cycle, REP times.
- Optional idle gap between repetitions.
- Feeds the detector's Sin input in test harnesses and on-board self-test.

Parameters:
- WIDTH, 4, pattern length in bits (2..16).
- GAP, 0, idle-level cycles inserted between repetitions (0..15).
- IDLE_LEVEL, 1'b1, Sout level when not transmitting and during gaps.

Ports:
- CP  input  1  clock, rising edge.
- nCR  input  1  reset, asynchronous, active-low.
- Start  input  1  transmit request; sampled on CP rising edge when Ready=1.
- Pattern  input  WIDTH  pattern to send, captured on accepted Start.
- Rep  input  4  repetition count, captured on accepted Start; 0 is treated as 1.
- Sout  output  1  registered serial data out.
- Ready  output  1  high when a Start will be accepted.
- Busy  output  1  high while shifting or in a gap.
- Done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (nCR=0, asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, Sout=IDLE_LEVEL, Ready=1, Busy=0, Done=0.
  - Counters and pattern register cleared; any transfer in progress is abandoned.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Ready=1, Busy=0, Sout=IDLE_LEVEL.
  - Start=1 at edge k: capture Pattern and Rep (Rep 0 becomes 1); go to SHIFT.
  - After edge k: Sout=Pattern[WIDTH-1], Busy=1, Ready=0.
- SHIFT:
  - After edges k+1..k+WIDTH-1: Sout = Pattern[WIDTH-2] .. Pattern[0].
  - Bit counter runs 0..WIDTH-1 and wraps to 0 at the end of each repetition.
  - End of a repetition, edge k+WIDTH, with repetitions remaining:
    - GAP=0: go back-to-back; Sout=Pattern[WIDTH-1] of the next repetition, no idle bit.
    - GAP>0: go to GAP; Sout=IDLE_LEVEL for exactly GAP cycles, then return to SHIFT with the MSB.
  - End of the last repetition: go to IDLE.
    - Sout=IDLE_LEVEL, Busy=0, Ready=1, Done=1 for exactly one cycle.
- Start while Busy=1 is ignored; no queuing.
  - Pattern and Rep changes during a transfer have no effect.
- Start held high continuously: it is accepted in the Done cycle (Ready=1).
  - The next transfer's MSB appears on the following cycle, so consecutive transfers have exactly one idle cycle between them.
- Transfer length in cycles = Rep_eff*WIDTH + (Rep_eff-1)*GAP.
- Repetition counter: 4-bit down-counter loaded with Rep_eff; it never underflows.

Decomposition:
- Shared package seq_pkg:
  - State encodings IDLE=2'b00, SHIFT=2'b01, GAP=2'b10 (2'b11 unused; recovers to IDLE).
  - Default pattern constant PAT_0101=4'b0101.
  - IDLE_LEVEL default.
  - The detector uses the same PAT_0101 constant.
- One sub-module, piso_shift:
  - WIDTH-bit parallel-in/serial-out register with load and shift enables.
  - Async active-low clear on nCR.
  - Pattern reload for each repetition is done from a held copy in the parent.

Test Plan:
- Reset then Start=1 for 1 cycle, Pattern=4'b0101, Rep=1, GAP=0:
  - Sout = 0,1,0,1 on cycles 1-4 after acceptance, then 1 (idle).
  - Done high on cycle 5 only; Busy high on cycles 1-4.
- Pattern=4'b0101, Rep=3, GAP=0:
  - Sout stream is 010101010101 (12 cycles, back-to-back), then Done.
  - Driving the detector's Sin with this stream gives a detector Out hit for each occurrence of 0101, counting overlaps.
- GAP=2, Pattern=4'b1100, Rep=2:
  - Sout = 1,1,0,0,1,1,1,1,0,0; Busy high for all 10 cycles; Done on cycle 11.
- Rep=0, Pattern=4'b1001:
  - Behaves as Rep=1: 4 bits 1,0,0,1 then Done.
  - Start pulsed again mid-transfer: ignored, sequence unchanged.
- Assert nCR=0 asynchronously at bit 2 of a transfer:
  - Sout=IDLE_LEVEL, Busy=0, Ready=1, Done=0 immediately, without waiting for a CP edge.
  - After release, a new Start transmits a clean full pattern.
- Start held high continuously, Pattern=4'b0110, Rep=1:
  - Sout = 0,1,1,0,1(idle, Done=1),0,1,1,0,...
  - Exactly one idle cycle between transfers.
